// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding, WIDTH limits and counter sizing
// for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// seq_mul_datapath: operand/partial-product registers, add/sub and shift.
// Signed support is built only with SEQ_MUL_SIGNED_EN defined.
module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               clear_i,
  input  logic               last_i,
  input  logic               is_signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] areg_q, hi_q, lo_q;
  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   sum;

  assign pp = lo_q[0] ? areg_q : '0;

`ifdef SEQ_MUL_SIGNED_EN
  logic           sgn_q;
  logic [WIDTH:0] hi_x, pp_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sgn_q <= 1'b0;
    end else if (clear_i) begin
      sgn_q <= 1'b0;
    end else if (load_i) begin
      sgn_q <= is_signed_i;
    end
  end

  assign hi_x = {sgn_q & hi_q[WIDTH-1], hi_q};
  assign pp_x = {sgn_q & pp[WIDTH-1], pp};
  // MSB of a signed multiplier carries negative weight
  assign sum  = (sgn_q && last_i) ? hi_x - pp_x : hi_x + pp_x;
`else
  logic unused_cfg;
  assign unused_cfg = is_signed_i ^ last_i;
  assign sum = {1'b0, hi_q} + {1'b0, pp};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      areg_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (clear_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (load_i) begin
      areg_q <= a_i;
      hi_q   <= '0;
      lo_q   <= b_i;
    end else if (step_i) begin
      hi_q   <= sum[WIDTH:1];
      lo_q   <= {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign product_o = {hi_q, lo_q};

endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: start/done/ack controller around the shift-add datapath.
// Optional macro SEQ_MUL_SIGNED_EN enables two's-complement mode.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  input  logic               ack,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_mul_unit: WIDTH out of range");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, clear, last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (ack && start) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else if (ack) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  seq_mul_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .step_i     (step),
    .clear_i    (clear),
    .last_i     (last),
    .is_signed_i(is_signed),
    .a_i        (a),
    .b_i        (b),
    .product_o  (product)
  );

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed checks of seq_mul_unit at WIDTH=8 and
// a back-to-back run at WIDTH=16.
module tb_seq_mul_unit;

  logic        clk;
  logic        reset_n;
  logic        start, abort, is_signed, ack;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  logic        start16, abort16, sgn16, ack16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] product16;

  int n_chk;
  int n_fail;
  int n;

  seq_mul_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .a(a), .b(b), .is_signed(is_signed), .busy(busy), .done(done),
    .ack(ack), .product(product)
  );

  seq_mul_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .abort(abort16),
    .a(a16), .b(b16), .is_signed(sgn16), .busy(busy16), .done(done16),
    .ack(ack16), .product(product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept a start, count edges to done, check latency and product, then ack
  task automatic run_mul(input string tag, input logic [7:0] ta,
                         input logic [7:0] tb, input logic ts,
                         input logic [15:0] exp);
    int c;
    a = ta; b = tb; is_signed = ts; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    c = 0;
    while (!done && c < 40) begin
      step();
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'd8);
    chk({tag, "_prod"}, 64'(product), 64'(exp));
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk({tag, "_ack"}, 64'(done), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0;
    start = 0; abort = 0; is_signed = 0; ack = 0; a = 0; b = 0;
    start16 = 0; abort16 = 0; sgn16 = 0; ack16 = 0; a16 = 0; b16 = 0;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", 64'(product), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    reset_n = 1'b1;
    step();

    // 13*11 with detailed timing and hold-until-ack
    a = 8'd13; b = 8'd11; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy0", 64'(busy), 64'd1);
    for (int i = 1; i < 8; i++) step();
    chk("t1_notdone", 64'({busy, done}), 64'b10);
    step();
    chk("t1_done", 64'({busy, done}), 64'b01);
    chk("t1_prod", 64'(product), 64'd143);
    ack = 1'b0;
    step(); step(); step();
    chk("t1_hold", 64'(done), 64'd1);
    chk("t1_holdp", 64'(product), 64'd143);
    // start in DONE without ack must be ignored
    a = 8'd1; b = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_nostart", 64'({busy, done}), 64'b01);
    chk("t1_nostartp", 64'(product), 64'd143);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t1_idle", 64'({busy, done}), 64'b00);

    run_mul("max", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_mul("zero", 8'h00, 8'd200, 1'b0, 16'h0000);
`ifdef SEQ_MUL_SIGNED_EN
    run_mul("sneg", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
`else
    run_mul("sneg", 8'hFD, 8'h05, 1'b1, 16'h04F1);
`endif
    run_mul("smin", 8'h80, 8'h80, 1'b1, 16'h4000);

    // abort on the 4th RUN cycle
    a = 8'd7; b = 8'd9; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_st", 64'({busy, done}), 64'b00);
    chk("abort_prod", 64'(product), 64'd0);
    run_mul("post_abort", 8'd7, 8'd9, 1'b0, 16'd63);

    // abort beats a simultaneous start
    a = 8'd3; b = 8'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start", 64'(busy), 64'd0);

    // start pulse during RUN is ignored
    a = 8'd20; b = 8'd30; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'd99; b = 8'd99; start = 1'b1;
    step();
    start = 1'b0;
    n = 3;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("ign_lat", 64'(n), 64'd8);
    chk("ign_prod", 64'(product), 64'd600);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // asynchronous reset in the middle of RUN
    a = 8'd50; b = 8'd60; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_st", 64'({busy, done}), 64'b00);
    chk("arst_prod", 64'(product), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    run_mul("post_rst", 8'd12, 8'd12, 1'b0, 16'd144);

    // WIDTH=16 back-to-back with ack and start held high
    a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1; ack16 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!done16 && n < 60);
      chk($sformatf("b2b_per%0d", r), 64'(n), 64'd17);
      chk($sformatf("b2b_prod%0d", r), 64'(product16), 64'hFFFE0001);
    end
    start16 = 1'b0;
    step();
    ack16 = 1'b0;
    chk("b2b_end", 64'({busy16, done16}), 64'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
